// File: rtl/dsm_pkg.sv
// Shared definitions for the second-order delta-sigma bitstream modulator.
package dsm_pkg;

   localparam logic MODE_INCR = 1'b0;
   localparam logic MODE_FREE = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } dsm_state_e;

   // Clamp a wide intermediate into the signed integrator range so overload never wraps.
   function automatic int sat_acc(input int value, input int accBits);
      int hiLim;
      int loLim;
      hiLim = (1 <<< (accBits - 1)) - 1;
      loLim = -(1 <<< (accBits - 1));
      if (value > hiLim) begin
         return hiLim;
      end
      if (value < loLim) begin
         return loLim;
      end
      return value;
   endfunction

endpackage

// File: rtl/dsm_bitstream_modulator_core.sv
// Integrator pair, one-bit quantizer and saturation of the modulator loop.
module dsm2_core
   import dsm_pkg::*;
#(
   parameter int IN_BITS  = 8,
   parameter int ACC_BITS = IN_BITS + 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      step_i,
   input  logic                      clear_i,
   input  logic signed [IN_BITS:0]   x_i,
   output logic                      q_o
);

   localparam int SW   = ACC_BITS + 2;
   localparam int HALF = 1 << (IN_BITS - 1);

   logic signed [ACC_BITS-1:0] i1_q, i2_q, i1_d, i2_d;
   logic signed [SW-1:0]       fbVal, i1Sum, i2Sum;

   assign q_o = ~i2_q[ACC_BITS-1];

   always_comb begin
      fbVal = q_o ? SW'(HALF) : -SW'(HALF);
      i1Sum = SW'(i1_q) + SW'(x_i) - fbVal;
      i1_d  = ACC_BITS'(sat_acc(int'(i1Sum), ACC_BITS));
      i2Sum = SW'(i2_q) + SW'(i1_d) - fbVal;
      i2_d  = ACC_BITS'(sat_acc(int'(i2Sum), ACC_BITS));
   end

   // A clear on the chaining edge overrides that edge's step: the last bit was already decided.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         i1_q <= '0;
         i2_q <= '0;
      end else if (step_i) begin
         i1_q <= i1_d;
         i2_q <= i2_d;
      end
   end

endmodule

// File: rtl/dsm_bitstream_modulator.sv
// Frame sequencer around the modulator core: handshake, bit counter and registered outputs.
module dsm_bitstream_modulator
   import dsm_pkg::*;
#(
   parameter int IN_BITS  = 8,
   parameter int M        = 16,
   parameter int ACC_BITS = IN_BITS + 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IN_BITS-1:0] in_data_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic               mode_i,
   output logic               bit_out_o,
   output logic               bit_valid_o,
   output logic               frame_start_o,
   output logic               busy_o
);

   localparam int             CW   = $clog2(M);
   localparam int             HALF = 1 << (IN_BITS - 1);
   localparam logic [CW-1:0]  LAST = CW'(M - 1);

   dsm_state_e           state_q;
   logic [CW-1:0]        count_q;
   logic [IN_BITS-1:0]   sample_q;
   logic                 mode_q, mode_d;
   logic                 bit_out_q, bit_valid_q, frame_start_q;
   logic                 lastBit, accept, coreQ;
   logic signed [IN_BITS:0] xVal;

   assign lastBit    = (state_q == ST_RUN) && (count_q == LAST);
   assign in_ready_o = !reset && ((state_q == ST_IDLE) || lastBit);
   assign accept     = in_valid_i && in_ready_o;
   assign mode_d     = accept ? mode_i : mode_q;
   assign xVal       = $signed({1'b0, sample_q} - (IN_BITS + 1)'(HALF));

   dsm2_core #(
      .IN_BITS  (IN_BITS),
      .ACC_BITS (ACC_BITS)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .step_i  (state_q == ST_RUN),
      .clear_i (accept && (mode_d == MODE_INCR)),
      .x_i     (xVal),
      .q_o     (coreQ)
   );

   // One modulator bit per RUN cycle; an accept on the last bit chains the next frame gaplessly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         count_q       <= '0;
         sample_q      <= '0;
         mode_q        <= MODE_INCR;
         bit_out_q     <= 1'b0;
         bit_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         if (accept) begin
            sample_q <= in_data_i;
         end
         case (state_q)
            ST_IDLE: begin
               bit_out_q     <= 1'b0;
               bit_valid_q   <= 1'b0;
               frame_start_q <= 1'b0;
               count_q       <= '0;
               if (accept) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               bit_out_q     <= coreQ;
               bit_valid_q   <= 1'b1;
               frame_start_q <= (count_q == '0);
               if (lastBit) begin
                  count_q <= '0;
                  if (!accept) begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  count_q <= count_q + CW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               count_q <= '0;
            end
         endcase
      end
   end

   assign bit_out_o     = bit_out_q;
   assign bit_valid_o   = bit_valid_q;
   assign frame_start_o = frame_start_q;
   assign busy_o        = (state_q == ST_RUN);

endmodule

// File: tb/tb_dsm_bitstream_modulator.sv
// Bench for the delta-sigma modulator: frame-level reference model plus directed density/pattern checks.
module tb_dsm_bitstream_modulator;

   localparam int IN_BITS = 8;
   localparam int M       = 16;
   localparam int HALF    = 128;
   localparam int ACC_MAX = 2047;
   localparam int ACC_MIN = -2048;

   logic         clk;
   logic         reset;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         mode;
   logic         bit_out;
   logic         bit_valid;
   logic         frame_start;
   logic         busy;

   int           checks;
   int           errors;
   logic [1:0]   expQ[$];
   int           mI1;
   int           mI2;
   logic         expValid, expBit, expFs, expBusy, modelKnown;
   int           onesCount;
   int           validCount;
   logic [15:0]  patLog;

   dsm_bitstream_modulator #(
      .IN_BITS  (IN_BITS),
      .M        (M),
      .ACC_BITS (IN_BITS + 4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_data_i     (in_data),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .mode_i        (mode),
      .bit_out_o     (bit_out),
      .bit_valid_o   (bit_valid),
      .frame_start_o (frame_start),
      .busy_o        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int clampAcc(input int v);
      if (v > ACC_MAX) return ACC_MAX;
      if (v < ACC_MIN) return ACC_MIN;
      return v;
   endfunction

   // Whole frame of expected bits computed at acceptance time from the sample and loop state.
   task automatic pushFrame(input logic [7:0] data, input logic m);
      int   x;
      int   fb;
      logic q;
      if (m == 1'b0) begin
         mI1 = 0;
         mI2 = 0;
      end
      x = int'(data) - HALF;
      for (int k = 0; k < M; k++) begin
         q   = (mI2 >= 0);
         fb  = q ? HALF : -HALF;
         mI1 = clampAcc(mI1 + x - fb);
         mI2 = clampAcc(mI2 + mI1 - fb);
         expQ.push_back({q, (k == 0)});
      end
   endtask

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkValue(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected range %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // One clock: check what the last edge produced, drive new inputs, then advance the model.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic m, input logic r);
      logic [1:0] e;
      logic       acc;
      @(negedge clk);
      if (modelKnown) begin
         checkOutput("bit_valid", bit_valid, expValid);
         checkOutput("bit_out", bit_out, expBit);
         checkOutput("frame_start", frame_start, expFs);
         checkOutput("busy", busy, expBusy);
      end
      if (bit_valid === 1'b1) begin
         validCount++;
         onesCount += int'(bit_out);
         patLog = {patLog[14:0], bit_out};
      end
      reset    = r;
      in_valid = v;
      in_data  = d;
      mode     = m;
      #1;
      checkOutput("in_ready", in_ready, !r && (expQ.size() <= 1));
      if (r) begin
         expQ.delete();
         mI1        = 0;
         mI2        = 0;
         expValid   = 1'b0;
         expBit     = 1'b0;
         expFs      = 1'b0;
         expBusy    = 1'b0;
         modelKnown = 1'b1;
      end else begin
         acc = v && (expQ.size() <= 1);
         if (expQ.size() > 0) begin
            e        = expQ.pop_front();
            expValid = 1'b1;
            expBit   = e[1];
            expFs    = e[0];
         end else begin
            expValid = 1'b0;
            expBit   = 1'b0;
            expFs    = 1'b0;
         end
         if (acc) begin
            pushFrame(d, m);
         end
         expBusy = (expQ.size() > 0);
      end
   endtask

   task automatic clearCounters();
      onesCount  = 0;
      validCount = 0;
   endtask

   initial begin
      logic [7:0] rd;
      logic       rv, rm, rr;
      checks     = 0;
      errors     = 0;
      mI1        = 0;
      mI2        = 0;
      modelKnown = 1'b0;
      expValid   = 1'b0;
      expBit     = 1'b0;
      expFs      = 1'b0;
      expBusy    = 1'b0;
      patLog     = '0;
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      mode       = 1'b0;
      clearCounters();

      repeat (3) applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);

      $display("[TB] incremental mid-scale frame");
      clearCounters();
      applyStimulus(1'b1, 8'd128, 1'b0, 1'b0);
      repeat (18) applyStimulus(1'b0, 8'd128, 1'b0, 1'b0);
      checkValue("s1_pattern", int'(patLog), 16'h9999);
      checkValue("s1_bits", validCount, 16);

      $display("[TB] free-running density at 3/4 scale");
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      clearCounters();
      for (int i = 0; i < 1009; i++) applyStimulus(1'b1, 8'd192, 1'b1, 1'b0);
      repeat (20) applyStimulus(1'b0, 8'd192, 1'b1, 1'b0);
      checkValue("s2_bits", validCount, 1024);
      checkRange("s2_ones", onesCount, 766, 770);

      $display("[TB] full-scale high then low");
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      clearCounters();
      for (int i = 0; i < 497; i++) applyStimulus(1'b1, 8'd255, 1'b1, 1'b0);
      repeat (20) applyStimulus(1'b0, 8'd255, 1'b1, 1'b0);
      checkValue("s3_high_bits", validCount, 512);
      checkRange("s3_high_ones", onesCount, 497, 512);
      clearCounters();
      for (int i = 0; i < 497; i++) applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
      repeat (20) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkValue("s3_low_bits", validCount, 512);
      checkRange("s3_low_ones", onesCount, 0, 15);

      $display("[TB] reset in the middle of a frame");
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'd128, 1'b0, 1'b0);
      repeat (7) applyStimulus(1'b1, 8'd128, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd128, 1'b0, 1'b1);
      clearCounters();
      applyStimulus(1'b1, 8'd128, 1'b0, 1'b0);
      repeat (18) applyStimulus(1'b0, 8'd128, 1'b0, 1'b0);
      checkValue("s4_pattern", int'(patLog), 16'h9999);
      checkValue("s4_bits", validCount, 16);

      $display("[TB] randomized handshake traffic");
      for (int i = 0; i < 400; i++) begin
         rv = ($urandom_range(0, 3) != 0);
         rd = 8'($urandom);
         rm = 1'($urandom);
         rr = ($urandom_range(0, 63) == 0);
         applyStimulus(rv, rd, rm, rr);
      end
      repeat (20) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
